// File: rtl/uart_rx_param_if.sv
// ============================================================================
// Module      : uart_rx_param_if
// Description : Serial input and received word/flag bundle of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_RX_Serial;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;

    // master = line/consumer side, slave = receiver
    modport master (
        output i_RX_Serial,
        input  o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break
    );

    modport slave (
        input  i_RX_Serial,
        output o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver with synchroniser, 3-sample majority
//               vote, parity/framing error flags and break detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_param #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  wire              i_Clock,
    input  wire              i_Rst_n,
    uart_rx_param_if.slave   rx_bus
);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 16383) begin : g_bad_clks_per_bit
        $error("uart_rx_param: CLKS_PER_BIT out of range 8..16383");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS out of range 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] c_half      = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_last_cnt  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_last_data = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_last_stop = IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_PARITY    = 3'd3;
    localparam logic [2:0] c_STOP      = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;

    logic [1:0]           r_sync;
    logic [2:0]           r_sh;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]     r_index;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_ferr;
    logic                 r_stops_low;

    logic                 r_dv;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_perr_o;
    logic                 r_ferr_o;
    logic                 r_break_o;

    logic w_line;
    logic w_bit_end;
    logic w_par_calc;
    logic w_par_err;
    logic w_ferr_next;
    logic w_stops_low_next;
    logic w_break_next;

    always_comb begin
        w_line           = (r_sh[0] & r_sh[1]) | (r_sh[0] & r_sh[2]) | (r_sh[1] & r_sh[2]);
        w_bit_end        = (r_count == c_last_cnt);
        w_par_calc       = (^r_shift) ^ r_par_bit;
        w_par_err        = (PARITY == 1) ? ~w_par_calc :
                           (PARITY == 2) ?  w_par_calc : 1'b0;
        w_ferr_next      = r_ferr | ~w_line;
        w_stops_low_next = r_stops_low & ~w_line;
        // Break: everything after the start bit, parity included, was low
        w_break_next     = (r_shift == '0) & ((PARITY == 0) | ~r_par_bit) & w_stops_low_next;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync      <= 2'b11;
            r_sh        <= 3'b111;
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_index     <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_ferr      <= 1'b0;
            r_stops_low <= 1'b0;
            r_dv        <= 1'b0;
            r_byte      <= '0;
            r_perr_o    <= 1'b0;
            r_ferr_o    <= 1'b0;
            r_break_o   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx_bus.i_RX_Serial};
            r_sh   <= {r_sh[1:0], r_sync[1]};
            r_dv   <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_count <= '0;
                    r_index <= '0;
                    if (!w_line) begin
                        r_state <= c_START;
                    end
                end

                c_START: begin
                    if (r_count == c_half) begin
                        r_count     <= '0;
                        r_par_bit   <= 1'b0;
                        r_ferr      <= 1'b0;
                        r_stops_low <= 1'b1;
                        r_state     <= w_line ? c_IDLE : c_DATA;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                c_DATA: begin
                    if (w_bit_end) begin
                        r_count <= '0;
                        r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
                        if (r_index == c_last_data) begin
                            r_index <= '0;
                            r_state <= (PARITY != 0) ? c_PARITY : c_STOP;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                c_PARITY: begin
                    if (w_bit_end) begin
                        r_count   <= '0;
                        r_par_bit <= w_line;
                        r_state   <= c_STOP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                c_STOP: begin
                    if (w_bit_end) begin
                        r_count <= '0;
                        if (r_index == c_last_stop) begin
                            r_index   <= '0;
                            r_dv      <= 1'b1;
                            r_byte    <= r_shift;
                            r_perr_o  <= w_par_err;
                            r_ferr_o  <= w_ferr_next;
                            r_break_o <= w_break_next;
                            r_state   <= w_ferr_next ? c_WAIT_IDLE : c_IDLE;
                        end else begin
                            r_index     <= r_index + 1'b1;
                            r_ferr      <= w_ferr_next;
                            r_stops_low <= w_stops_low_next;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                // A low line after a framing error must go high before re-arming
                c_WAIT_IDLE: begin
                    r_count <= '0;
                    if (w_line) begin
                        r_state <= c_IDLE;
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign rx_bus.o_RX_DV      = r_dv;
    assign rx_bus.o_RX_Byte    = r_byte;
    assign rx_bus.o_Parity_Err = r_perr_o;
    assign rx_bus.o_Frame_Err  = r_ferr_o;
    assign rx_bus.o_Break      = r_break_o;

endmodule

`default_nettype wire
